// File: rtl/tile_pkg.sv
// Shared types and helpers for the double-buffered tile loader:
// FSM state encoding, index-width helper and DW-to-OW element extension.
package tile_pkg;

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

  // Index width for a range of n entries; never narrower than one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Sign- or zero-extends the low dw bits of w to the full 64-bit word.
  function automatic logic [63:0] ext(input logic [63:0] w, input int dw, input logic sgn);
    logic [63:0] upper;
    logic        fill;
    upper = ~64'd0 << dw;
    fill  = sgn & (|(w & (64'd1 << (dw - 1))));
    return fill ? (w | upper) : (w & ~upper);
  endfunction

endpackage

// File: rtl/up_counter_wrap.sv
// Up-counter that wraps from MAX back to zero; wrap flags the enabled
// cycle in which the count sits at MAX.
module up_counter_wrap #(
  parameter int SIZE = 4,
  parameter int MAX  = 15
) (
  input  logic            clock,
  input  logic            reset_n,
  input  logic            clr,
  input  logic            en,
  output logic [SIZE-1:0] count,
  output logic            wrap
);

  assign wrap = en && (count == SIZE'(MAX));

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)  count <= '0;
    else if (clr)  count <= '0;
    else if (en)   count <= wrap ? '0 : count + 1'b1;
  end

endmodule

// File: rtl/tile_loader_dbuf.sv
// Ping-pong tile loader: streams a strided ROWS x COLS tile from SRAM into the
// write bank while the other bank serves extended full-row reads.
module tile_loader_dbuf
  import tile_pkg::*;
#(
  parameter int AW     = 18,
  parameter int DW     = 16,
  parameter int OW     = 22,
  parameter int ROWS   = 8,
  parameter int COLS   = 8,
  parameter int RD_LAT = 1
) (
  input  logic                      clock,
  input  logic                      reset_n,
  input  logic                      start,
  input  logic [AW-1:0]             base_addr,
  input  logic [AW-1:0]             row_stride,
  input  logic                      sign_mode,
  output logic                      r_en,
  output logic [AW-1:0]             r_addr,
  input  logic [DW-1:0]             r_data,
  input  logic [idx_w(ROWS)-1:0]    rd_row,
  output logic [COLS*OW-1:0]        row_out,
  output logic                      rd_bank,
  output logic                      busy,
  output logic                      done
);

  localparam int ROW_W = idx_w(ROWS);
  localparam int COL_W = idx_w(COLS);
  localparam int LAT_W = idx_w(RD_LAT);

  state_t            state, state_nxt;
  logic              accept;
  logic              wr_bank;
  logic [AW-1:0]     row_base, stride_q;
  logic [ROW_W-1:0]  row_q;
  logic [COL_W-1:0]  col_q;
  logic [LAT_W-1:0]  drain_cnt_unused;
  logic              col_wrap, row_wrap, drain_wrap;

  logic [RD_LAT-1:0] vld_p;
  logic [ROW_W-1:0]  row_p [RD_LAT];
  logic [COL_W-1:0]  col_p [RD_LAT];

  logic [DW-1:0]     bank_mem [2][ROWS][COLS];

  assign accept = (state == IDLE) && start;
  assign r_en   = (state == ISSUE);
  assign busy   = (state != IDLE);
  assign done   = (state == DONE);

  up_counter_wrap #(.SIZE(COL_W), .MAX(COLS - 1)) u_col (
    .clock(clock), .reset_n(reset_n), .clr(accept), .en(r_en),
    .count(col_q), .wrap(col_wrap)
  );

  up_counter_wrap #(.SIZE(ROW_W), .MAX(ROWS - 1)) u_row (
    .clock(clock), .reset_n(reset_n), .clr(accept), .en(col_wrap),
    .count(row_q), .wrap(row_wrap)
  );

  up_counter_wrap #(.SIZE(LAT_W), .MAX(RD_LAT - 1)) u_drain (
    .clock(clock), .reset_n(reset_n), .clr(state != DRAIN), .en(state == DRAIN),
    .count(drain_cnt_unused), .wrap(drain_wrap)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start)      state_nxt = ISSUE;
      ISSUE:   if (row_wrap)   state_nxt = DRAIN;
      DRAIN:   if (drain_wrap) state_nxt = DONE;
      DONE:                    state_nxt = IDLE;
      default:                 state_nxt = IDLE;
    endcase
  end

  // Address generation: r_addr is registered so it is valid alongside r_en.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_addr  <= '0;
      rd_bank <= 1'b0;
      wr_bank <= 1'b0;
    end else begin
      if (accept) begin
        r_addr  <= base_addr;
        wr_bank <= ~rd_bank;
      end else if (r_en) begin
        r_addr  <= col_wrap ? row_base + stride_q : r_addr + 1'b1;
      end
      if (done) rd_bank <= ~rd_bank;
    end
  end

  always_ff @(posedge clock) begin
    if (accept) begin
      row_base <= base_addr;
      stride_q <= row_stride;
    end else if (r_en && col_wrap) begin
      row_base <= row_base + stride_q;
    end
  end

  // Write pipeline: tag each issued read, land it RD_LAT cycles later.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) vld_p <= '0;
    else          vld_p <= (vld_p << 1) | RD_LAT'(r_en);
  end

  always_ff @(posedge clock) begin
    row_p[0] <= row_q;
    col_p[0] <= col_q;
    for (int i = 1; i < RD_LAT; i++) begin
      row_p[i] <= row_p[i-1];
      col_p[i] <= col_p[i-1];
    end
  end

  always_ff @(posedge clock) begin
    if (vld_p[RD_LAT-1])
      bank_mem[wr_bank][row_p[RD_LAT-1]][col_p[RD_LAT-1]] <= r_data;
  end

  // Readout: element 0 lands in the most significant slot.
  always_comb begin
    row_out = '0;
    if (int'(rd_row) < ROWS) begin
      for (int c = 0; c < COLS; c++)
        row_out[(COLS-c)*OW-1 -: OW] = OW'(ext(64'(bank_mem[rd_bank][rd_row][c]), DW, sign_mode));
    end
  end

endmodule

// File: doc/tile_loader_dbuf.md
Name: tile_loader_dbuf

Overview:
- Parametrised successor to the fixed 8x8 SRAM-to-local-buffer loader.
- Fetches a ROWS x COLS tile of DW-bit words from a strided region of an external synchronous SRAM into one of two local banks (ping-pong).
- Concurrently serves full-row reads, sign- or zero-extended to OW bits, from the other bank.
- Sits between the SRAM port and the datapath that consumes one tile row per cycle.

Parameters:
- AW, 18: SRAM address width.
- DW, 16: SRAM data / stored element width.
- OW, 22: output element width; OW >= DW.
- ROWS, 8: tile rows; must be >= 1.
- COLS, 8: tile columns; must be >= 1.
- RD_LAT, 1: SRAM read latency in cycles, from r_en to r_data valid; must be >= 1.

Ports:
- clock  in  1  sole clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  single-cycle load request; sampled only in IDLE.
- base_addr  in  AW  tile origin address; latched on an accepted start.
- row_stride  in  AW  address distance between consecutive tile rows; latched on an accepted start.
- sign_mode  in  1  1 = sign-extend on readout, 0 = zero-extend; combinational.
- r_en  out  1  SRAM read strobe.
- r_addr  out  AW  SRAM read address.
- r_data  in  DW  SRAM read data; valid RD_LAT cycles after the matching r_en.
- rd_row  in  clog2(ROWS)  row index to read out.
- row_out  out  COLS*OW  selected row of the read bank.
- rd_bank  out  1  bank currently serving reads.
- busy  out  1  high from the cycle after an accepted start through the DONE state.
- done  out  1  one-cycle pulse when a load completes.

Behaviour:
- Reset (asynchronous, reset_n=0):
  - state=IDLE; busy=0, done=0, r_en=0, r_addr=0, rd_bank=0; write pipeline cleared.
  - Bank contents are not reset; row_out is unspecified until the first done.
- FSM states: IDLE, ISSUE, DRAIN, DONE.
- IDLE:
  - start=1 -> latch base_addr, row_stride; wr_bank = ~rd_bank; row=0, col=0; go to ISSUE.
  - start=0 -> stay in IDLE.
- ISSUE:
  - r_en=1 and r_addr = base + row*stride + col, mod 2^AW. Addresses are registered: r_addr is valid in the same cycle r_en is high.
  - col increments each cycle; at COLS-1, col wraps to 0 and row increments.
  - Exactly ROWS*COLS consecutive r_en cycles, with no bubbles.
  - After the last issue -> DRAIN.
- Write pipeline:
  - An RD_LAT-deep shift register carries {valid, row, col} alongside each read.
  - When its output is valid, r_data is written to bank[wr_bank][row][col].
- DRAIN:
  - r_en=0; wait until the pipeline is empty (RD_LAT cycles after the last issue), then -> DONE.
- DONE (one cycle):
  - done=1; rd_bank toggles at the end of this cycle; -> IDLE.
- Latency: done asserts ROWS*COLS + RD_LAT + 1 cycles after the accepted start cycle. Defaults: 66.
- start in ISSUE, DRAIN or DONE is ignored: no queueing, no restart.
- Readout (combinational from bank[rd_bank]):
  - Element c of rd_row occupies row_out[(COLS-c)*OW-1 -: OW], so element 0 is at the MSBs.
  - Each element is extended from DW to OW per sign_mode.
  - rd_row >= ROWS -> row_out = 0.
- Loads never disturb the read bank. The new tile becomes visible only in the cycle after done.
- Reset during ISSUE/DRAIN: the load is aborted, rd_bank is unchanged (0 after reset), and no done pulse is issued.
- row_stride=0 is legal: every row fetches the same addresses.
- Address overflow wraps modulo 2^AW silently.

Decomposition:
- Shared package tile_pkg:
  - FSM state enum (IDLE/ISSUE/DRAIN/DONE).
  - Width helpers: ROW_W=clog2(ROWS), COL_W=clog2(COLS).
  - Sign/zero extension function ext(DW to OW, mode).
- One sub-module: up_counter_wrap (parameters: size, max; ports: clock, reset_n, clr, en, count, wrap).
  - Used for col, for row (enabled on col wrap), and for the DRAIN count.

Test Plan:
- Basic load, defaults: SRAM model returns addr[15:0]; start with base=0x100, stride=0x40, sign_mode=0 -> done at cycle 66; rd_bank=1; rd_row=2 gives elements 0x180..0x187, element 0 in the MSBs, upper 6 bits zero.
- Sign extension: word 0x8001 loaded at row0/col0; sign_mode=1 -> element 0 = 22'h3F8001; sign_mode=0 -> 22'h008001, same cycle.
- Ping-pong: a second load with base=0x2000 runs while rd_row sweeps the first tile -> row_out matches tile 1 until done, then tile 2; rd_bank returns to 0.
- Latency and robustness: RD_LAT=3, ROWS=4, COLS=2 -> exactly 8 r_en cycles, done 12 cycles after start; start pulses mid-load are ignored.
- Wrap-around: AW=8, base=0xF0, stride=0x10 -> row 1 addresses wrap to 0x00..0x07.
- Abort: reset_n=0 at the 20th ISSUE cycle, then release -> IDLE, r_en=0, rd_bank=0, no done pulse; a following load completes normally.
